// File: rtl/cpu_pkg.sv
// Shared opcode constants, FSM state encoding, instruction classes and control-strobe bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  // The ALU adds during fetch to increment the PC.
  localparam logic [4:0] ALU_ADD = OP_ADD;

  // T0..T7 are consecutive so a step advance is a simple increment.
  typedef enum logic [3:0] {
    RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_RTYPE, CLS_IMM, CLS_LD, CLS_LDI, CLS_ST,
    CLS_BR, CLS_MULDIV, CLS_SINGLE, CLS_NOP, CLS_HALT
  } op_class_e;

  typedef struct packed {
    logic pc_out;     logic mdr_out;    logic zlow_out;  logic zhigh_out;
    logic hi_out;     logic lo_out;     logic inport_out; logic c_out;
    logic ba_out;     logic r_out;
    logic pc_en;      logic inc_pc;     logic mar_en;    logic mdr_en;
    logic mdr_read;   logic ir_en;      logic y_en;      logic zlow_in;
    logic zhigh_in;   logic hi_en;      logic lo_en;     logic r_in;
    logic con_en;     logic outport_en; logic ram_write;
    logic gra;        logic grb;        logic grc;
  } ctrl_t;

  // Final step of each instruction class; the FSM leaves for T0 or HALT from here.
  function automatic state_e last_step(input op_class_e c);
    case (c)
      CLS_RTYPE, CLS_IMM, CLS_LDI: return T5;
      CLS_LD, CLS_ST:              return T7;
      CLS_BR, CLS_MULDIV:          return T6;
      CLS_SINGLE:                  return T3;
      default:                     return T2;
    endcase
  endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Maps the 5-bit opcode onto the instruction class that selects the execute sequence.
// Latency: purely combinational.
// Backpressure: none.
module opcode_class_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_e  op_class
);

  // Undefined opcodes fall into the no-op class.
  always_comb begin
    op_class = CLS_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL:    op_class = CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:          op_class = CLS_IMM;
      OP_LD:                             op_class = CLS_LD;
      OP_LDI:                            op_class = CLS_LDI;
      OP_ST:                             op_class = CLS_ST;
      OP_BR:                             op_class = CLS_BR;
      OP_MUL, OP_DIV:                    op_class = CLS_MULDIV;
      OP_JR, OP_IN, OP_OUT,
      OP_MFHI, OP_MFLO:                  op_class = CLS_SINGLE;
      OP_HALT:                           op_class = CLS_HALT;
      default:                           op_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the CPU: fetch T0-T2, class-specific execute T3-T7, HALT.
// Latency: one state per Clock; instructions take 3 to 8 cycles.
// Backpressure: none; Stop is honoured only at the final step of an instruction.
module control_unit
  import cpu_pkg::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout, MDRout, ZLowout, ZHighout, HIout, LOout,
  output logic        InPortout, Cout, BAout, R_out,
  output logic        PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read,
  output logic        IR_enable, Y_enable, ZLowIn, ZHighIn, HI_enable,
  output logic        LO_enable, R_in, CON_enable, OutPort_enable, RAM_write,
  output logic        Gra, Grb, Grc,
  output logic [4:0]  ALU_op
);

  state_e    state_q, state_d;
  op_class_e op_class;
  ctrl_t     ctl;
  logic      unused_ir;

  // Only the opcode field steers sequencing; register fields go straight to the datapath.
  assign unused_ir = ^IR[26:0];

  opcode_class_decode u_dec (
    .opcode   (IR[31:27]),
    .op_class (op_class)
  );

  // State register; Clear forces RESET immediately, even mid-instruction.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state_q <= RESET;
    else        state_q <= state_d;
  end

  // Step sequencing; T7 always ends an instruction so a stray IR change cannot run past it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET:   state_d = T0;
      HALT:    state_d = HALT;
      default: begin
        if (state_q == last_step(op_class) || state_q == T7)
          state_d = (op_class == CLS_HALT || Stop) ? HALT : T0;
        else
          state_d = state_e'(state_q + 4'd1);
      end
    endcase
  end

  // Strobe decode from state and class; CON_FF gates the branch PC load directly.
  always_comb begin
    ctl    = '0;
    ALU_op = 5'b00000;
    case (state_q)
      T0: begin ctl.pc_out = 1'b1; ctl.mar_en = 1'b1; ctl.inc_pc = 1'b1; ctl.zlow_in = 1'b1; ALU_op = ALU_ADD; end
      T1: begin ctl.zlow_out = 1'b1; ctl.pc_en = 1'b1; ctl.mdr_read = 1'b1; ctl.mdr_en = 1'b1; ALU_op = ALU_ADD; end
      T2: begin ctl.mdr_out = 1'b1; ctl.ir_en = 1'b1; ALU_op = ALU_ADD; end
      T3: begin
        ALU_op = IR[31:27];
        case (op_class)
          CLS_RTYPE, CLS_IMM:      begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_en = 1'b1; end
          CLS_LD, CLS_LDI, CLS_ST: begin ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_en = 1'b1; end
          CLS_BR:                  begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_en = 1'b1; end
          CLS_MULDIV:              begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_en = 1'b1; end
          CLS_SINGLE: begin
            case (IR[31:27])
              OP_JR:   begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_en = 1'b1; end
              OP_IN:   begin ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
              OP_OUT:  begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.outport_en = 1'b1; end
              OP_MFHI: begin ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
              OP_MFLO: begin ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      T4: begin
        ALU_op = IR[31:27];
        case (op_class)
          CLS_RTYPE:                        begin ctl.grc = 1'b1; ctl.r_out = 1'b1; ctl.zlow_in = 1'b1; end
          CLS_IMM, CLS_LD, CLS_LDI, CLS_ST: begin ctl.c_out = 1'b1; ctl.zlow_in = 1'b1; end
          CLS_BR:                           begin ctl.pc_out = 1'b1; ctl.y_en = 1'b1; end
          CLS_MULDIV:                       begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.zlow_in = 1'b1; ctl.zhigh_in = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        ALU_op = IR[31:27];
        case (op_class)
          CLS_RTYPE, CLS_IMM, CLS_LDI: begin ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
          CLS_LD, CLS_ST:              begin ctl.zlow_out = 1'b1; ctl.mar_en = 1'b1; end
          CLS_BR:                      begin ctl.c_out = 1'b1; ctl.zlow_in = 1'b1; end
          CLS_MULDIV:                  begin ctl.zlow_out = 1'b1; ctl.lo_en = 1'b1; end
          default: ;
        endcase
      end
      T6: begin
        ALU_op = IR[31:27];
        case (op_class)
          CLS_LD:     begin ctl.mdr_read = 1'b1; ctl.mdr_en = 1'b1; end
          CLS_ST:     begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_en = 1'b1; end
          CLS_BR:     begin ctl.zlow_out = 1'b1; ctl.pc_en = CON_FF; end
          CLS_MULDIV: begin ctl.zhigh_out = 1'b1; ctl.hi_en = 1'b1; end
          default: ;
        endcase
      end
      T7: begin
        ALU_op = IR[31:27];
        case (op_class)
          CLS_LD:  begin ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
          CLS_ST:  ctl.ram_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign Run            = (state_q != HALT);
  assign PCout          = ctl.pc_out;
  assign MDRout         = ctl.mdr_out;
  assign ZLowout        = ctl.zlow_out;
  assign ZHighout       = ctl.zhigh_out;
  assign HIout          = ctl.hi_out;
  assign LOout          = ctl.lo_out;
  assign InPortout      = ctl.inport_out;
  assign Cout           = ctl.c_out;
  assign BAout          = ctl.ba_out;
  assign R_out          = ctl.r_out;
  assign PC_enable      = ctl.pc_en;
  assign IncPC          = ctl.inc_pc;
  assign MAR_enable     = ctl.mar_en;
  assign MDR_enable     = ctl.mdr_en;
  assign MDR_read       = ctl.mdr_read;
  assign IR_enable      = ctl.ir_en;
  assign Y_enable       = ctl.y_en;
  assign ZLowIn         = ctl.zlow_in;
  assign ZHighIn        = ctl.zhigh_in;
  assign HI_enable      = ctl.hi_en;
  assign LO_enable      = ctl.lo_en;
  assign R_in           = ctl.r_in;
  assign CON_enable     = ctl.con_en;
  assign OutPort_enable = ctl.outport_en;
  assign RAM_write      = ctl.ram_write;
  assign Gra            = ctl.gra;
  assign Grb            = ctl.grb;
  assign Grc            = ctl.grc;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, async-clear corner case, random instructions.
// Latency: n/a.
// Backpressure: n/a.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Clear, CON_FF, Stop;
  logic [31:0] IR;
  logic        Run;
  logic        PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout, BAout, R_out;
  logic        PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read, IR_enable, Y_enable;
  logic        ZLowIn, ZHighIn, HI_enable, LO_enable, R_in, CON_enable, OutPort_enable, RAM_write;
  logic        Gra, Grb, Grc;
  logic [4:0]  ALU_op;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 Clock = ~Clock;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
    .PCout(PCout), .MDRout(MDRout), .ZLowout(ZLowout), .ZHighout(ZHighout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
    .R_out(R_out), .PC_enable(PC_enable), .IncPC(IncPC), .MAR_enable(MAR_enable),
    .MDR_enable(MDR_enable), .MDR_read(MDR_read), .IR_enable(IR_enable),
    .Y_enable(Y_enable), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HI_enable(HI_enable),
    .LO_enable(LO_enable), .R_in(R_in), .CON_enable(CON_enable),
    .OutPort_enable(OutPort_enable), .RAM_write(RAM_write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .ALU_op(ALU_op)
  );

  // Strobe names by bit position in the observed mask; indices 0..9 are the bus drivers.
  string nm [28] = '{"PCout", "MDRout", "ZLowout", "ZHighout", "HIout", "LOout",
                     "InPortout", "Cout", "BAout", "R_out", "PC_enable", "IncPC",
                     "MAR_enable", "MDR_enable", "MDR_read", "IR_enable", "Y_enable",
                     "ZLowIn", "ZHighIn", "HI_enable", "LO_enable", "R_in", "CON_enable",
                     "OutPort_enable", "RAM_write", "Gra", "Grb", "Grc"};

  localparam string FETCH0 = "PCout MAR_enable IncPC ZLowIn";

  // Expected strobe list per step for the instruction under test.
  string exp_s [8];

  function automatic logic [27:0] dut_mask();
    return {Grc, Grb, Gra, RAM_write, OutPort_enable, CON_enable, R_in, LO_enable,
            HI_enable, ZHighIn, ZLowIn, Y_enable, IR_enable, MDR_read, MDR_enable,
            MAR_enable, IncPC, PC_enable, R_out, BAout, Cout, InPortout, LOout,
            HIout, ZHighout, ZLowout, MDRout, PCout};
  endfunction

  // Turn a space-separated list of strobe names into a mask; unknown names poison the mask.
  function automatic logic [27:0] to_mask(input string s);
    logic [27:0] m = '0;
    string tok = "";
    bit found;
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s[i] == " ") begin
        if (tok.len() > 0) begin
          found = 1'b0;
          for (int j = 0; j < 28; j++) if (tok == nm[j]) begin m[j] = 1'b1; found = 1'b1; end
          if (!found) m = '1;
        end
        tok = "";
      end else begin
        tok = {tok, s.substr(i, i)};
      end
    end
    return m;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference sequence of strobes per opcode, taken from the instruction step listings.
  task automatic build_model(input logic [4:0] op, input bit con, output int last);
    string ld3 = "Grb BAout Y_enable";
    string ld4 = "Cout ZLowIn";
    exp_s = '{"", "", "", "", "", "", "", ""};
    exp_s[0] = FETCH0;
    exp_s[1] = "ZLowout PC_enable MDR_read MDR_enable";
    exp_s[2] = "MDRout IR_enable";
    last = 2;
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: begin
        exp_s[3] = "Grb R_out Y_enable"; exp_s[4] = "Grc R_out ZLowIn";
        exp_s[5] = "ZLowout Gra R_in"; last = 5;
      end
      5'd11, 5'd12, 5'd13: begin
        exp_s[3] = "Grb R_out Y_enable"; exp_s[4] = "Cout ZLowIn";
        exp_s[5] = "ZLowout Gra R_in"; last = 5;
      end
      5'd0: begin
        exp_s[3] = ld3; exp_s[4] = ld4; exp_s[5] = "ZLowout MAR_enable";
        exp_s[6] = "MDR_read MDR_enable"; exp_s[7] = "MDRout Gra R_in"; last = 7;
      end
      5'd1: begin exp_s[3] = ld3; exp_s[4] = ld4; exp_s[5] = "ZLowout Gra R_in"; last = 5; end
      5'd2: begin
        exp_s[3] = ld3; exp_s[4] = ld4; exp_s[5] = "ZLowout MAR_enable";
        exp_s[6] = "Gra R_out MDR_enable"; exp_s[7] = "RAM_write"; last = 7;
      end
      5'd18: begin
        exp_s[3] = "Gra R_out CON_enable"; exp_s[4] = "PCout Y_enable"; exp_s[5] = "Cout ZLowIn";
        exp_s[6] = con ? "ZLowout PC_enable" : "ZLowout"; last = 6;
      end
      5'd14, 5'd15: begin
        exp_s[3] = "Gra R_out Y_enable"; exp_s[4] = "Grb R_out ZLowIn ZHighIn";
        exp_s[5] = "ZLowout LO_enable"; exp_s[6] = "ZHighout HI_enable"; last = 6;
      end
      5'd19: begin exp_s[3] = "Gra R_out PC_enable";      last = 3; end
      5'd21: begin exp_s[3] = "InPortout Gra R_in";       last = 3; end
      5'd22: begin exp_s[3] = "Gra R_out OutPort_enable"; last = 3; end
      5'd23: begin exp_s[3] = "HIout Gra R_in";           last = 3; end
      5'd24: begin exp_s[3] = "LOout Gra R_in";           last = 3; end
      default: last = 2;
    endcase
  endtask

  // Entered at a falling edge with the DUT in T0; leaves at the falling edge after the last step.
  task automatic run_instr(input logic [31:0] ir, input bit con, input int stop_at,
                           input int n_steps, input bit exp_halt, input string tag);
    int last;
    logic [27:0] m;
    build_model(ir[31:27], con, last);
    IR = ir; CON_FF = con; Stop = 1'b0;
    for (int t = 0; t < n_steps; t++) begin
      if (t == stop_at) Stop = 1'b1;
      m = dut_mask();
      cmp($sformatf("%s T%0d strobes", tag, t), {4'b0, m}, {4'b0, to_mask(exp_s[t])});
      cmp($sformatf("%s T%0d ALU_op", tag, t), {27'b0, ALU_op}, {27'b0, (t < 3) ? 5'b00011 : ir[31:27]});
      cmp($sformatf("%s T%0d Run", tag, t), {31'b0, Run}, 32'd1);
      cmp($sformatf("%s T%0d bus_onehot", tag, t), {31'b0, $countones(m[9:0]) <= 1}, 32'd1);
      @(negedge Clock);
    end
    Stop = 1'b0;
    if (exp_halt) begin
      cmp({tag, " end halt strobes"}, {4'b0, dut_mask()}, 32'd0);
      cmp({tag, " end Run"}, {31'b0, Run}, 32'd0);
    end else begin
      cmp({tag, " end back to T0"}, {4'b0, dut_mask()}, {4'b0, to_mask(FETCH0)});
      cmp({tag, " end Run"}, {31'b0, Run}, 32'd1);
    end
  endtask

  // HALT must ignore Stop, IR and CON_FF activity.
  task automatic halt_hold(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      Stop = $urandom_range(0, 1); CON_FF = $urandom_range(0, 1); IR = $urandom;
      cmp($sformatf("%s halt%0d strobes", tag, k), {4'b0, dut_mask()}, 32'd0);
      cmp($sformatf("%s halt%0d Run", tag, k), {31'b0, Run}, 32'd0);
      @(negedge Clock);
    end
    Stop = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge Clock);
    Clear = 1'b0;
    #1;
    cmp({tag, " rst strobes"}, {4'b0, dut_mask()}, 32'd0);
    cmp({tag, " rst ALU_op"}, {27'b0, ALU_op}, 32'd0);
    cmp({tag, " rst Run"}, {31'b0, Run}, 32'd1);
    @(negedge Clock);
    cmp({tag, " rst held strobes"}, {4'b0, dut_mask()}, 32'd0);
    Clear = 1'b1;
    @(negedge Clock);
    cmp({tag, " first T0"}, {4'b0, dut_mask()}, {4'b0, to_mask(FETCH0)});
    cmp({tag, " first T0 ALU_op"}, {27'b0, ALU_op}, 32'd3);
  endtask

  typedef struct {
    logic [31:0] ir;
    bit          con;
    int          stop_at;
    int          cycles;
    bit          halts;
  } vec_t;

  vec_t vt [14];

  initial begin
    int last, stop_at, op;
    bit halts;
    logic [31:0] ir;

    Clear = 1'b0; IR = '0; CON_FF = 1'b0; Stop = 1'b0;

    vt[0]  = '{32'h59080002, 1'b0, -1, 6, 1'b0};  // addi
    vt[1]  = '{32'h00800000, 1'b0, -1, 8, 1'b0};  // ld
    vt[2]  = '{32'h10000000, 1'b0, -1, 8, 1'b0};  // st
    vt[3]  = '{32'h90000000, 1'b0, -1, 7, 1'b0};  // branch not taken
    vt[4]  = '{32'h90000000, 1'b1, -1, 7, 1'b0};  // branch taken
    vt[5]  = '{32'h18000000, 1'b0, -1, 6, 1'b0};  // add
    vt[6]  = '{32'h70000000, 1'b0, -1, 7, 1'b0};  // mul
    vt[7]  = '{32'hB8000000, 1'b0, -1, 4, 1'b0};  // mfhi
    vt[8]  = '{32'hC8000000, 1'b0, -1, 3, 1'b0};  // nop
    vt[9]  = '{32'h08000000, 1'b0, -1, 6, 1'b0};  // ldi
    vt[10] = '{32'h98000000, 1'b0, -1, 4, 1'b0};  // jr
    vt[11] = '{32'hF8000000, 1'b0, -1, 3, 1'b0};  // undefined opcode
    vt[12] = '{32'h18000000, 1'b0,  4, 6, 1'b1};  // add with Stop raised at T4
    vt[13] = '{32'hD0000000, 1'b0, -1, 3, 1'b1};  // halt

    do_reset("por");

    for (int i = 0; i < 14; i++) begin
      run_instr(vt[i].ir, vt[i].con, vt[i].stop_at, vt[i].cycles, vt[i].halts,
                $sformatf("vec%0d", i));
      if (vt[i].halts) begin
        halt_hold(20, $sformatf("vec%0d", i));
        do_reset($sformatf("vec%0d", i));
      end
    end

    // Clear dropped between edges during T5 of ld must zero the strobes without waiting for a clock.
    IR = 32'h00800000; CON_FF = 1'b0;
    repeat (5) @(negedge Clock);
    cmp("clr ld T5 strobes", {4'b0, dut_mask()}, {4'b0, to_mask("ZLowout MAR_enable")});
    #2 Clear = 1'b0;
    #1;
    cmp("clr async strobes", {4'b0, dut_mask()}, 32'd0);
    cmp("clr async ALU_op", {27'b0, ALU_op}, 32'd0);
    cmp("clr async Run", {31'b0, Run}, 32'd1);
    @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    cmp("clr first T0", {4'b0, dut_mask()}, {4'b0, to_mask(FETCH0)});

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 31);
      ir = {op[4:0], 27'($urandom)};
      stop_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : -1;
      build_model(op[4:0], 1'b0, last);
      halts = (op == 26) || (stop_at >= 0 && stop_at <= last);
      run_instr(ir, 1'($urandom_range(0, 1)), stop_at, last + 1, halts, $sformatf("rnd%0d op%0d", i, op));
      if (halts) begin
        halt_hold(3, $sformatf("rnd%0d", i));
        do_reset($sformatf("rnd%0d", i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
